// File: rtl/uart_rx_core_if.sv
// ---------------------------------------------------------------------------
// uart_rx_core_if
// Character delivery interface between the UART receiver and its consumer.
//   data       : received character, LSB = first bit on the line
//   valid      : data and error flags hold a character
//   ready      : consumer accepts; transfer when valid && ready
//   parity_err : parity mismatch for the presented character (qualified by valid)
//   frame_err  : a stop bit was sampled 0 (qualified by valid)
//   overrun    : sticky; a character was lost while valid was high
// Modports: master = receiver side, slave = consumer side.
// ---------------------------------------------------------------------------
interface uart_rx_core_if #(
  parameter int DATA_BITS = 8
) ();
  logic [DATA_BITS-1:0] data;
  logic                 valid;
  logic                 ready;
  logic                 parity_err;
  logic                 frame_err;
  logic                 overrun;

  modport master (
    output data, valid, parity_err, frame_err, overrun,
    input  ready
  );

  modport slave (
    input  data, valid, parity_err, frame_err, overrun,
    output ready
  );
endinterface

// File: rtl/uart_rx_core.sv
// ---------------------------------------------------------------------------
// uart_rx_core
// Parametrised UART receiver. Oversamples the asynchronous line 16x, rejects
// false starts, frames a configurable character and presents it on a
// valid/ready interface with per-character error flags and a sticky overrun.
//
// Ports:
//   clk    : system clock, all state on the rising edge
//   rst    : asynchronous active-high reset
//   i_rx   : serial line, idle high, asynchronous to clk
//   o_busy : high while a frame is in progress (state != IDLE)
//   m_if   : uart_rx_core_if.master (data/valid/ready/parity_err/frame_err/overrun)
//
// Optional feature macro: UART_RX_MAJORITY_EN
//   defined     : each bit decided by 2-of-3 majority of samples at sc 6/7/8
//   not defined : a single sample at sc 7 decides each bit
// ---------------------------------------------------------------------------
module uart_rx_core #(
  parameter int CLK_HZ    = 100000000,
  parameter int BAUD      = 9600,
  parameter int DATA_BITS = 8,
  parameter int PARITY    = 0,
  parameter int STOP_BITS = 1
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           i_rx,
  output logic           o_busy,
  uart_rx_core_if.master m_if
);

  localparam int DIV_RAW = (CLK_HZ + 8 * BAUD) / (16 * BAUD);
  localparam int DIV     = (DIV_RAW < 1) ? 1 : DIV_RAW;
  localparam int DIV_W   = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int BIT_W   = $clog2(DATA_BITS);
  localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(DATA_BITS - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP
  } state_t;

  state_t               r_state;
  state_t               w_state_nxt;
  logic                 r_sync1;
  logic                 r_sync2;
  logic [1:0]           r_flush;
  logic                 r_armed;
  logic [DIV_W-1:0]     r_div_cnt;
  logic                 w_tick;
  logic                 w_rx_s;
  logic [3:0]           r_sc;
  logic [BIT_W-1:0]     r_bit_idx;
  logic                 r_stop_idx;
  logic                 w_stop_last;
  logic [DATA_BITS-1:0] r_shift;
  logic                 r_par_bit;
  logic                 r_ferr;
  logic                 w_bit;
  logic                 w_false_start;
  logic                 w_last_stop;
  logic                 w_shift_en;
  logic                 w_par_en;
  logic                 w_stop1_en;
  logic                 w_done;
  logic                 w_perr;
  logic                 w_ferr;
  logic [DATA_BITS-1:0] r_data;
  logic                 r_valid;
  logic                 r_perr;
  logic                 r_ferr_out;
  logic                 r_overrun;

  // Synchroniser. r_flush marks when r_sync2 holds a genuine line sample
  // rather than its reset value, so a line held low through reset cannot arm.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sync1 <= 1'b1;
      r_sync2 <= 1'b1;
      r_flush <= 2'b00;
      r_armed <= 1'b0;
    end else begin
      r_sync1 <= i_rx;
      r_sync2 <= r_sync1;
      r_flush <= {r_flush[0], 1'b1};
      if (r_flush[1] && r_sync2)
        r_armed <= 1'b1;
    end
  end

  assign w_rx_s = r_sync2;

  // Free-running 16x tick generator.
  assign w_tick = (r_div_cnt == DIV_W'(DIV - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      r_div_cnt <= '0;
    else if (w_tick)
      r_div_cnt <= '0;
    else
      r_div_cnt <= r_div_cnt + DIV_W'(1);
  end

`ifdef UART_RX_MAJORITY_EN
  localparam logic [3:0] DECIDE_SC = 4'd8;
  logic r_s6;
  logic r_s7;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_s6 <= 1'b1;
      r_s7 <= 1'b1;
    end else if (w_tick) begin
      if (r_sc == 4'd6) r_s6 <= w_rx_s;
      if (r_sc == 4'd7) r_s7 <= w_rx_s;
    end
  end

  // Evaluated at sc 8 with the live sample as the third vote.
  assign w_bit         = (r_s6 & r_s7) | (r_s6 & w_rx_s) | (r_s7 & w_rx_s);
  // At sc 7 only two votes exist; a false start needs both to read high.
  assign w_false_start = r_s6 & w_rx_s;
  // The final stop completes at sc 7, so it is judged on two votes: an
  // error only when both read low.
  assign w_last_stop   = r_s6 | w_rx_s;
`else
  localparam logic [3:0] DECIDE_SC = 4'd7;
  assign w_bit         = w_rx_s;
  assign w_false_start = w_rx_s;
  assign w_last_stop   = w_rx_s;
`endif

  assign w_stop_last = (STOP_BITS == 1) ? 1'b1 : r_stop_idx;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      r_state <= S_IDLE;
    else
      r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_shift_en  = 1'b0;
    w_par_en    = 1'b0;
    w_stop1_en  = 1'b0;
    w_done      = 1'b0;
    if (w_tick) begin
      case (r_state)
        S_IDLE: begin
          if (r_armed && !w_rx_s)
            w_state_nxt = S_START;
        end
        S_START: begin
          if (r_sc == 4'd7 && w_false_start)
            w_state_nxt = S_IDLE;
          else if (r_sc == 4'd15)
            w_state_nxt = S_DATA;
        end
        S_DATA: begin
          if (r_sc == DECIDE_SC)
            w_shift_en = 1'b1;
          if (r_sc == 4'd15 && r_bit_idx == LAST_BIT)
            w_state_nxt = (PARITY != 0) ? S_PARITY : S_STOP;
        end
        S_PARITY: begin
          if (r_sc == DECIDE_SC)
            w_par_en = 1'b1;
          if (r_sc == 4'd15)
            w_state_nxt = S_STOP;
        end
        S_STOP: begin
          if (w_stop_last) begin
            if (r_sc == 4'd7) begin
              w_done      = 1'b1;
              w_state_nxt = S_IDLE;
            end
          end else if (r_sc == DECIDE_SC) begin
            w_stop1_en = 1'b1;
          end
        end
        default: w_state_nxt = S_IDLE;
      endcase
    end
  end

  // Bit timing counters and the character being assembled.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sc       <= '0;
      r_bit_idx  <= '0;
      r_stop_idx <= 1'b0;
      r_shift    <= '0;
      r_par_bit  <= 1'b0;
      r_ferr     <= 1'b0;
    end else if (w_tick) begin
      if (r_state == S_IDLE) begin
        r_sc       <= '0;
        r_bit_idx  <= '0;
        r_stop_idx <= 1'b0;
        r_ferr     <= 1'b0;
      end else begin
        r_sc <= r_sc + 4'd1;
        if (r_state == S_DATA && r_sc == 4'd15)
          r_bit_idx <= r_bit_idx + BIT_W'(1);
        if (r_state == S_STOP && r_sc == 4'd15)
          r_stop_idx <= 1'b1;
      end
      if (w_shift_en)
        r_shift <= {w_bit, r_shift[DATA_BITS-1:1]};
      if (w_par_en)
        r_par_bit <= w_bit;
      if (w_stop1_en && !w_bit)
        r_ferr <= 1'b1;
    end
  end

  always_comb begin
    w_perr = 1'b0;
    if (PARITY == 1)
      w_perr = ~(^r_shift ^ r_par_bit);
    else if (PARITY == 2)
      w_perr = ^r_shift ^ r_par_bit;
  end

  assign w_ferr = r_ferr | ~w_last_stop;

  // Output holding register. A completing character loads whenever the slot
  // is empty or is being emptied this cycle; otherwise it is dropped.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_data     <= '0;
      r_valid    <= 1'b0;
      r_perr     <= 1'b0;
      r_ferr_out <= 1'b0;
      r_overrun  <= 1'b0;
    end else begin
      if (w_done && (!r_valid || m_if.ready)) begin
        r_data     <= r_shift;
        r_perr     <= w_perr;
        r_ferr_out <= w_ferr;
        r_valid    <= 1'b1;
      end else if (r_valid && m_if.ready) begin
        r_valid <= 1'b0;
      end
      if (w_done && r_valid && !m_if.ready)
        r_overrun <= 1'b1;
      else if (r_valid && m_if.ready)
        r_overrun <= 1'b0;
    end
  end

  assign m_if.data       = r_data;
  assign m_if.valid      = r_valid;
  assign m_if.parity_err = r_perr;
  assign m_if.frame_err  = r_ferr_out;
  assign m_if.overrun    = r_overrun;
  assign o_busy          = (r_state != S_IDLE);

endmodule

// File: tb/tb_uart_rx_core.sv
// ---------------------------------------------------------------------------
// tb_uart_rx_core
// Bench for uart_rx_core. Two instances share the clock and reset:
//   dut A : 8N1
//   dut B : 7 data bits, even parity, 1 stop
// CLK_HZ = 1536000, BAUD = 9600 -> 10 clk per tick, 160 clk per bit.
// Expected characters are queued when a frame is driven and compared when
// the receiver presents them.
// ---------------------------------------------------------------------------
module tb_uart_rx_core;

  localparam int BIT_CLK = 160;

  typedef struct packed {
    logic [8:0] d;
    logic       pe;
    logic       fe;
  } exp_t;

  logic clk;
  logic rst;
  logic rx_a;
  logic rx_b;
  logic busy_a;
  logic busy_b;

  uart_rx_core_if #(.DATA_BITS(8)) if_a ();
  uart_rx_core_if #(.DATA_BITS(7)) if_b ();

  uart_rx_core #(
    .CLK_HZ(1536000), .BAUD(9600), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1)
  ) u_dut_a (
    .clk(clk), .rst(rst), .i_rx(rx_a), .o_busy(busy_a), .m_if(if_a)
  );

  uart_rx_core #(
    .CLK_HZ(1536000), .BAUD(9600), .DATA_BITS(7), .PARITY(2), .STOP_BITS(1)
  ) u_dut_b (
    .clk(clk), .rst(rst), .i_rx(rx_b), .o_busy(busy_b), .m_if(if_b)
  );

  exp_t q_a[$];
  exp_t q_b[$];
  exp_t e_a;
  exp_t e_b;
  int   n_tests = 0;
  int   n_fail  = 0;
  int   n_rx_a  = 0;
  int   n_rx_b  = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Scoreboard: compare each accepted character with the head of its queue.
  always @(negedge clk) begin
    if (!rst && if_a.valid && if_a.ready) begin
      n_rx_a++;
      check_eq("a_expected_pending", 32'(q_a.size() > 0), 32'd1);
      if (q_a.size() > 0) begin
        e_a = q_a.pop_front();
        check_eq("a_data", 32'(if_a.data), 32'(e_a.d[7:0]));
        check_eq("a_parity_err", 32'(if_a.parity_err), 32'(e_a.pe));
        check_eq("a_frame_err", 32'(if_a.frame_err), 32'(e_a.fe));
      end
    end
  end

  always @(negedge clk) begin
    if (!rst && if_b.valid && if_b.ready) begin
      n_rx_b++;
      check_eq("b_expected_pending", 32'(q_b.size() > 0), 32'd1);
      if (q_b.size() > 0) begin
        e_b = q_b.pop_front();
        check_eq("b_data", 32'(if_b.data), 32'(e_b.d[6:0]));
        check_eq("b_parity_err", 32'(if_b.parity_err), 32'(e_b.pe));
        check_eq("b_frame_err", 32'(if_b.frame_err), 32'(e_b.fe));
      end
    end
  end

  task automatic set_line(input int sel, input logic v);
    if (sel == 0) rx_a = v;
    else          rx_b = v;
  endtask

  // One bit period; optionally with a one-tick inverted pulse near mid-bit.
  task automatic drive_bit(input int sel, input logic v, input bit glitch);
    set_line(sel, v);
    if (glitch) begin
      repeat (80) @(posedge clk);
      set_line(sel, ~v);
      repeat (10) @(posedge clk);
      set_line(sel, v);
      repeat (BIT_CLK - 90) @(posedge clk);
    end else begin
      repeat (BIT_CLK) @(posedge clk);
    end
  endtask

  // par < 0: no parity bit; otherwise par[0] is driven as the parity bit.
  task automatic send_frame(input int sel, input logic [8:0] d, input int nd,
                            input int par, input logic stop, input int gbit);
    drive_bit(sel, 1'b0, 1'b0);
    for (int i = 0; i < nd; i++)
      drive_bit(sel, d[i], (i == gbit));
    if (par >= 0)
      drive_bit(sel, par[0], 1'b0);
    drive_bit(sel, stop, 1'b0);
    set_line(sel, 1'b1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int  rx_before;
    bit  busy_seen;
    logic [6:0] b_data;
    logic [7:0] rst_data;

    rst        = 1'b1;
    rx_a       = 1'b1;
    rx_b       = 1'b1;
    if_a.ready = 1'b1;
    if_b.ready = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    check_eq("rst_valid", 32'(if_a.valid), 32'd0);
    check_eq("rst_data", 32'(if_a.data), 32'd0);
    check_eq("rst_parity_err", 32'(if_a.parity_err), 32'd0);
    check_eq("rst_frame_err", 32'(if_a.frame_err), 32'd0);
    check_eq("rst_overrun", 32'(if_a.overrun), 32'd0);
    check_eq("rst_busy", 32'(busy_a), 32'd0);
    rst = 1'b0;
    repeat (40) @(posedge clk);

    // 8N1 clean character
    q_a.push_back('{d: 9'h0A5, pe: 1'b0, fe: 1'b0});
    send_frame(0, 9'h0A5, 8, -1, 1'b1, -1);
    repeat (40) @(posedge clk);
    @(negedge clk);
    check_eq("a5_drained", 32'(q_a.size()), 32'd0);
    check_eq("a5_count", 32'(n_rx_a), 32'd1);
    check_eq("a5_busy_after", 32'(busy_a), 32'd0);
    check_eq("a5_overrun", 32'(if_a.overrun), 32'd0);

    // 7E1: wrong then right parity bit
    b_data = 7'h03;
    for (int p = 1; p >= 0; p--) begin
      q_b.push_back('{d: {2'b00, b_data}, pe: (p[0] != ^b_data), fe: 1'b0});
      send_frame(1, {2'b00, b_data}, 7, p, 1'b1, -1);
      repeat (40) @(posedge clk);
    end
    @(negedge clk);
    check_eq("par_drained", 32'(q_b.size()), 32'd0);
    check_eq("par_count", 32'(n_rx_b), 32'd2);

    // Stop bit low, then a clean character
    q_a.push_back('{d: 9'h055, pe: 1'b0, fe: 1'b1});
    send_frame(0, 9'h055, 8, -1, 1'b0, -1);
    repeat (320) @(posedge clk);
    q_a.push_back('{d: 9'h00F, pe: 1'b0, fe: 1'b0});
    send_frame(0, 9'h00F, 8, -1, 1'b1, -1);
    repeat (40) @(posedge clk);
    @(negedge clk);
    check_eq("ferr_drained", 32'(q_a.size()), 32'd0);
    check_eq("ferr_count", 32'(n_rx_a), 32'd3);

    // 30 clk low glitch on an idle line
    rx_before = n_rx_a;
    busy_seen = 1'b0;
    rx_a = 1'b0;
    for (int i = 0; i < 250; i++) begin
      if (i == 30) rx_a = 1'b1;
      @(negedge clk);
      if (busy_a) busy_seen = 1'b1;
    end
    check_eq("glitch_busy_seen", 32'(busy_seen), 32'd1);
    check_eq("glitch_busy_after", 32'(busy_a), 32'd0);
    check_eq("glitch_no_valid", 32'(n_rx_a - rx_before), 32'd0);
    check_eq("glitch_valid_low", 32'(if_a.valid), 32'd0);

    // Overrun: consumer stalled across two characters
    if_a.ready = 1'b0;
    q_a.push_back('{d: 9'h011, pe: 1'b0, fe: 1'b0});
    send_frame(0, 9'h011, 8, -1, 1'b1, -1);
    send_frame(0, 9'h022, 8, -1, 1'b1, -1);
    repeat (20) @(posedge clk);
    @(negedge clk);
    check_eq("ovr_valid_held", 32'(if_a.valid), 32'd1);
    check_eq("ovr_data_held", 32'(if_a.data), 32'h11);
    check_eq("ovr_flag", 32'(if_a.overrun), 32'd1);
    @(posedge clk);
    #1 if_a.ready = 1'b1;
    @(posedge clk);
    #1 if_a.ready = 1'b0;
    @(negedge clk);
    check_eq("ovr_valid_clr", 32'(if_a.valid), 32'd0);
    check_eq("ovr_flag_clr", 32'(if_a.overrun), 32'd0);
    check_eq("ovr_drained", 32'(q_a.size()), 32'd0);
    if_a.ready = 1'b1;
    repeat (40) @(posedge clk);

    // Reset in the middle of bit 4, line then held low
    rst_data  = 8'h3C;
    rx_before = n_rx_a;
    drive_bit(0, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++)
      drive_bit(0, rst_data[i], 1'b0);
    rx_a = 1'b0;
    repeat (80) @(posedge clk);
    #1 rst = 1'b1;
    repeat (5) @(posedge clk);
    #1 rst = 1'b0;
    repeat (800) @(negedge clk);
    check_eq("rst_mid_busy", 32'(busy_a), 32'd0);
    check_eq("rst_mid_valid", 32'(if_a.valid), 32'd0);
    check_eq("rst_mid_no_char", 32'(n_rx_a - rx_before), 32'd0);
    rx_a = 1'b1;
    repeat (100) @(posedge clk);
    q_a.push_back('{d: 9'h03C, pe: 1'b0, fe: 1'b0});
    send_frame(0, 9'h03C, 8, -1, 1'b1, -1);
    repeat (40) @(posedge clk);
    @(negedge clk);
    check_eq("rst_recover_drained", 32'(q_a.size()), 32'd0);
    check_eq("rst_recover_count", 32'(n_rx_a - rx_before), 32'd1);

`ifdef UART_RX_MAJORITY_EN
    // One-tick inverted pulse inside data bit 2 is outvoted
    q_a.push_back('{d: 9'h03C, pe: 1'b0, fe: 1'b0});
    send_frame(0, 9'h03C, 8, -1, 1'b1, 2);
    repeat (40) @(posedge clk);
    @(negedge clk);
    check_eq("maj_drained", 32'(q_a.size()), 32'd0);
    check_eq("maj_count", 32'(n_rx_a - rx_before), 32'd2);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
